// File: rtl/iq_comp_adapt.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : iq_comp_adapt                                               |
// | Purpose  : Blind adaptive I/Q-imbalance compensator, y = x + w*conj(x) |
// |            with LMS weight adaptation, fixed or seeded weights.        |
// | Revision : 1.0 - initial parametrised release with valid handshake    |
// +------------------------------------------------------------------------+
module iq_comp_adapt #(
  parameter int DW         = 4,
  parameter int WW         = 13,
  parameter int FRAC       = 10,
  parameter int MU_SHIFT   = 6,
  parameter int SETTLE_TOL = 1,
  parameter int SETTLE_CNT = 256
) (
  input  logic                 clk,
  input  logic                 RESETn,
  input  logic                 in_valid,
  input  logic [DW-1:0]        Ix,
  input  logic [DW-1:0]        Qx,
  input  logic [1:0]           op_mode,
  input  logic                 freeze_iqcomp,
  input  logic signed [WW-1:0] Wr_in,
  input  logic signed [WW-1:0] Wj_in,
  output logic                 out_valid,
  output logic signed [DW-1:0] Iy,
  output logic signed [DW-1:0] Qy,
  output logic signed [WW-1:0] Wr,
  output logic signed [WW-1:0] Wj,
  output logic                 settled
);

  localparam int PW = DW + WW;                      // full product width
  localparam int SW = PW + 2;                       // stage-2 sum width
  localparam int EW = 2 * DW + 2;                   // error term width
  localparam int UW = ((WW > EW) ? WW : EW) + 1;    // weight update width
  localparam int CW = $clog2(SETTLE_CNT + 1);

  localparam logic [1:0] MODE_BYP   = 2'b00;
  localparam logic [1:0] MODE_FIXED = 2'b10;
  localparam logic [1:0] MODE_SEED  = 2'b11;

  localparam logic signed [SW-1:0] D_MAX = SW'(2 ** (DW - 1) - 1);
  localparam logic signed [SW-1:0] D_MIN = SW'(-(2 ** (DW - 1)));
  localparam logic signed [UW-1:0] W_MAX = UW'(2 ** (WW - 1) - 1);
  localparam logic signed [UW-1:0] W_MIN = UW'(-(2 ** (WW - 1)));
  localparam logic signed [UW-1:0] TOL_P = UW'(SETTLE_TOL);
  localparam logic signed [UW-1:0] TOL_N = UW'(-SETTLE_TOL);
  localparam logic [CW-1:0]        CNT_MAX = CW'(SETTLE_CNT);

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [SW-1:0] v);
    if (v > D_MAX)      return D_MAX[DW-1:0];
    else if (v < D_MIN) return D_MIN[DW-1:0];
    else                return v[DW-1:0];
  endfunction

  function automatic logic signed [WW-1:0] sat_ww(input logic signed [UW-1:0] v);
    if (v > W_MAX)      return W_MAX[WW-1:0];
    else if (v < W_MIN) return W_MIN[WW-1:0];
    else                return v[WW-1:0];
  endfunction

  // Offset-binary to two's complement is an MSB flip.
  logic signed [DW-1:0] xi, xq;
  assign xi = {~Ix[DW-1], Ix[DW-2:0]};
  assign xq = {~Qx[DW-1], Qx[DW-2:0]};

  logic signed [WW-1:0] wr_q, wj_q, wr_d, wj_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 settled_q, settled_d;
  logic [1:0]           mode_q;

  logic                 v1_q, byp_q;
  logic signed [DW-1:0] xi_q, xq_q;
  logic signed [PW-1:0] p_rxi_q, p_jxq_q, p_jxi_q, p_rxq_q;

  logic                 ov_q;
  logic signed [DW-1:0] iy_q, qy_q;

  // Stage 1: capture centred samples and the four cross products.
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      v1_q    <= 1'b0;
      byp_q   <= 1'b0;
      xi_q    <= '0;
      xq_q    <= '0;
      p_rxi_q <= '0;
      p_jxq_q <= '0;
      p_jxi_q <= '0;
      p_rxq_q <= '0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        byp_q   <= (op_mode == MODE_BYP);
        xi_q    <= xi;
        xq_q    <= xq;
        p_rxi_q <= PW'(wr_q) * PW'(xi);
        p_jxq_q <= PW'(wj_q) * PW'(xq);
        p_jxi_q <= PW'(wj_q) * PW'(xi);
        p_rxq_q <= PW'(wr_q) * PW'(xq);
      end
    end
  end

  logic signed [SW-1:0] sum_i, sum_q, yi_full, yq_full;
  logic signed [DW-1:0] iy_d, qy_d;
  assign sum_i   = SW'(p_rxi_q) + SW'(p_jxq_q);
  assign sum_q   = SW'(p_jxi_q) - SW'(p_rxq_q);
  assign yi_full = (sum_i >>> FRAC) + SW'(xi_q);
  assign yq_full = (sum_q >>> FRAC) + SW'(xq_q);
  assign iy_d    = byp_q ? xi_q : sat_dw(yi_full);
  assign qy_d    = byp_q ? xq_q : sat_dw(yq_full);

  // Stage 2: saturated compensated output; holds while no valid sample.
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      ov_q <= 1'b0;
      iy_q <= '0;
      qy_q <= '0;
    end else begin
      ov_q <= v1_q;
      if (v1_q) begin
        iy_q <= iy_d;
        qy_q <= qy_d;
      end
    end
  end

  // LMS error terms from the registered outputs.
  logic signed [EW-1:0] err_r, err_j;
  logic signed [UW-1:0] wr_upd_full, wj_upd_full, dwr, dwj;
  logic signed [WW-1:0] wr_upd, wj_upd;
  logic                 in_tol, mode_chg;
  assign err_r       = EW'(iy_q) * EW'(iy_q) - EW'(qy_q) * EW'(qy_q);
  assign err_j       = (EW'(iy_q) * EW'(qy_q)) <<< 1;
  assign wr_upd_full = UW'(wr_q) - UW'(err_r >>> MU_SHIFT);
  assign wj_upd_full = UW'(wj_q) - UW'(err_j >>> MU_SHIFT);
  assign wr_upd      = sat_ww(wr_upd_full);
  assign wj_upd      = sat_ww(wj_upd_full);
  assign dwr         = UW'(wr_upd) - UW'(wr_q);
  assign dwj         = UW'(wj_upd) - UW'(wj_q);
  assign in_tol      = (dwr <= TOL_P) && (dwr >= TOL_N) && (dwj <= TOL_P) && (dwj >= TOL_N);
  assign mode_chg    = (op_mode != mode_q);

  // Weight / settle next-state: mode handling takes priority over freeze.
  always_comb begin
    wr_d      = wr_q;
    wj_d      = wj_q;
    cnt_d     = cnt_q;
    settled_d = settled_q;
    case (op_mode)
      MODE_BYP: begin
        cnt_d     = '0;
        settled_d = 1'b0;
      end
      MODE_FIXED: begin
        wr_d      = Wr_in;
        wj_d      = Wj_in;
        cnt_d     = '0;
        settled_d = 1'b0;
      end
      default: begin
        if (op_mode == MODE_SEED && mode_q != MODE_SEED) begin
          wr_d      = Wr_in;
          wj_d      = Wj_in;
          cnt_d     = '0;
          settled_d = 1'b0;
        end else begin
          if (!freeze_iqcomp && ov_q) begin
            wr_d = wr_upd;
            wj_d = wj_upd;
            if (in_tol) begin
              cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
              settled_d = (cnt_d == CNT_MAX);
            end else begin
              cnt_d     = '0;
              settled_d = 1'b0;
            end
          end
          if (mode_chg) begin
            cnt_d     = '0;
            settled_d = 1'b0;
          end
        end
      end
    endcase
  end

  // Weight, settle and previous-mode registers.
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      wr_q      <= '0;
      wj_q      <= '0;
      cnt_q     <= '0;
      settled_q <= 1'b0;
      mode_q    <= MODE_BYP;
    end else begin
      wr_q      <= wr_d;
      wj_q      <= wj_d;
      cnt_q     <= cnt_d;
      settled_q <= settled_d;
      mode_q    <= op_mode;
    end
  end

  assign out_valid = ov_q;
  assign Iy        = iy_q;
  assign Qy        = qy_q;
  assign Wr        = wr_q;
  assign Wj        = wj_q;
  assign settled   = settled_q;

endmodule
`default_nettype wire

// File: tb/tb_iq_comp_adapt.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_iq_comp_adapt                                            |
// | Purpose  : Directed self-checking bench for iq_comp_adapt              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_iq_comp_adapt;

  localparam int DW = 4;
  localparam int WW = 13;

  logic                 clk = 1'b0;
  logic                 RESETn = 1'b0;
  logic                 in_valid = 1'b0;
  logic [DW-1:0]        ix = 4'h8;
  logic [DW-1:0]        qx = 4'h8;
  logic [1:0]           mode = 2'b00;
  logic                 freeze = 1'b0;
  logic signed [WW-1:0] wr_in = '0;
  logic signed [WW-1:0] wj_in = '0;

  logic                 ov, st, ov2, st2;
  logic signed [DW-1:0] iy, qy, iy2, qy2;
  logic signed [WW-1:0] wr, wj, wr2, wj2;

  int n_cmp = 0;
  int n_bad = 0;
  int applied;
  int nov;

  always #5 clk = ~clk;

  // Default-parameter instance.
  iq_comp_adapt u_dut (
    .clk(clk), .RESETn(RESETn), .in_valid(in_valid), .Ix(ix), .Qx(qx),
    .op_mode(mode), .freeze_iqcomp(freeze), .Wr_in(wr_in), .Wj_in(wj_in),
    .out_valid(ov), .Iy(iy), .Qy(qy), .Wr(wr), .Wj(wj), .settled(st)
  );

  // Large-step instance for the single LMS step vector.
  iq_comp_adapt #(.MU_SHIFT(2)) u_dut_mu2 (
    .clk(clk), .RESETn(RESETn), .in_valid(in_valid), .Ix(ix), .Qx(qx),
    .op_mode(mode), .freeze_iqcomp(freeze), .Wr_in(wr_in), .Wj_in(wj_in),
    .out_valid(ov2), .Iy(iy2), .Qy(qy2), .Wr(wr2), .Wj(wj2), .settled(st2)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One valid sample, then in_valid low; returns at the negedge where out_valid rises.
  task automatic one_sample(input logic [DW-1:0] i, input logic [DW-1:0] q);
    ix = i; qx = q; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    #1;
    check_eq("rst_ov", ov, 0);
    check_eq("rst_iy", iy, 0);
    check_eq("rst_qy", qy, 0);
    check_eq("rst_wr", wr, 0);
    check_eq("rst_wj", wj, 0);
    check_eq("rst_st", st, 0);
    #20 RESETn = 1'b1;
    @(negedge clk);

    // Bypass with latency and hold
    mode = 2'b00;
    ix = 4'hB; qx = 4'h5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("byp_lat1_ov", ov, 0);
    @(negedge clk);
    check_eq("byp_ov", ov, 1);
    check_eq("byp_iy", iy, 3);
    check_eq("byp_qy", qy, -3);
    check_eq("byp_wr", wr, 0);
    check_eq("byp_wj", wj, 0);
    @(negedge clk);
    check_eq("byp_gap_ov", ov, 0);
    check_eq("byp_hold_iy", iy, 3);

    // Single adaptive step from w=0
    mode = 2'b01;
    @(negedge clk);
    one_sample(4'hC, 4'h8);
    check_eq("ad_ov", ov2, 1);
    check_eq("ad_iy", iy2, 4);
    check_eq("ad_qy", qy2, 0);
    @(negedge clk);
    check_eq("ad_wr_mu2", wr2, -4);
    check_eq("ad_wj_mu2", wj2, 0);
    check_eq("ad_wr_mu6", wr, 0);

    // Fixed weights
    mode = 2'b10; wr_in = 13'sd512; wj_in = 13'sd0;
    @(negedge clk);
    one_sample(4'hC, 4'hA);
    check_eq("fix_iy", iy, 6);
    check_eq("fix_qy", qy, 1);
    check_eq("fix_wr", wr, 512);
    wr_in = 13'sd4095;
    @(negedge clk);
    one_sample(4'hF, 4'hA);
    check_eq("fix_sat_pos_iy", iy, 7);
    check_eq("fix_qy_floor", qy, -6);
    one_sample(4'h0, 4'h8);
    check_eq("fix_sat_neg_iy", iy, -8);
    check_eq("fix_qy_zero", qy, 0);

    // Seeded entry while frozen: the load still happens
    mode = 2'b00;
    @(negedge clk);
    mode = 2'b11; wr_in = 13'sd100; wj_in = -13'sd50; freeze = 1'b1;
    @(negedge clk);
    check_eq("seed_wr", wr, 100);
    check_eq("seed_wj", wj, -50);
    check_eq("seed_st", st, 0);
    wr_in = '0; wj_in = '0;
    nov = 0;
    for (int k = 0; k < 22; k++) begin
      if (k < 20) begin
        ix = 4'($urandom_range(15, 0));
        qx = 4'($urandom_range(15, 0));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (ov) nov++;
    end
    check_eq("frz_nout", nov, 20);
    check_eq("frz_wr", wr, 100);
    check_eq("frz_wj", wj, -50);

    // Unfrozen step from the seeded weights
    freeze = 1'b0;
    one_sample(4'hF, 4'h8);
    check_eq("seed_ad_iy", iy, 7);
    check_eq("seed_ad_qy", qy, -1);
    @(negedge clk);
    check_eq("seed_ad_wr", wr, 100);
    check_eq("seed_ad_wj", wj, -49);

    // Settle count: small balanced samples keep every step within tolerance
    mode = 2'b00;
    @(negedge clk);
    mode = 2'b01;
    @(negedge clk);
    applied = 0;
    for (int k = 0; k < 264; k++) begin
      if (k < 262) begin
        ix = 4'($urandom_range(11, 5));
        qx = 4'($urandom_range(11, 5));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (applied == 255) check_eq("settle_at_255", st, 0);
      if (applied == 256) check_eq("settle_at_256", st, 1);
      if (ov) applied++;
    end
    check_eq("settle_updates", applied, 262);
    check_eq("settle_final", st, 1);
    mode = 2'b00;
    @(negedge clk);
    check_eq("settle_clr_mode", st, 0);

    // Asynchronous reset mid-stream
    ix = 4'hB; qx = 4'h5; in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("pre_rst_iy", iy, 3);
    #2 RESETn = 1'b0;
    #1;
    check_eq("arst_ov", ov, 0);
    check_eq("arst_iy", iy, 0);
    check_eq("arst_wr2", wr2, 0);
    @(negedge clk);
    RESETn = 1'b1;
    @(negedge clk);
    check_eq("post_rst_lat1", ov, 0);
    @(negedge clk);
    check_eq("post_rst_ov", ov, 1);
    check_eq("post_rst_iy", iy, 3);
    in_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
